// File: rtl/cla_pkg.sv
// Shared constants and types for the nibble-serial CLA operand sequencer.
// Holds nibble geometry, default adder latency and the sequencer FSM encoding.
package cla_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NIBBLES = 4;
  localparam int WIDTH = NIBBLE_W * NIBBLES;
  localparam int ADD_LAT_DEF = 1;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] nib_idx_t;

endpackage

// File: rtl/cla_lat_counter.sv
// Loadable down-counter timing the adder-stage latency window.
// Ports: clk, res (async low), load/load_val, en (count down), done (count==0).
module cla_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cla_operand_sequencer.sv
// Feeds a 16-bit add through an external 4-bit adder one nibble at a time.
// Ports: in_* operand handshake, add_* to/from adder stage, out_* result.
module cla_operand_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = cla_pkg::WIDTH,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   a,
  input  logic [WIDTH:1]   b,
  input  logic             cin_in,
  output logic [NIBBLE_W:1] add_x,
  output logic [NIBBLE_W:1] add_y,
  output logic             add_cin,
  input  logic [NIBBLE_W:1] add_z,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   sum,
  output logic             cout_out,
  output logic             ov
);

  // WAIT counts ADD_LAT cycles: load ADD_LAT-1, capture when it hits 0.
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (ADD_LAT == 0) ? '0 : CNT_W'(ADD_LAT - 1);

  state_t           state_q, state_d;
  nib_idx_t         k_q;
  logic [WIDTH:1]   a_q, b_q, sum_q;
  logic             carry_q;
  logic             rdy_q;
  logic             accept, capture, load_cnt;
  logic             cnt_en, cnt_done, busy;
  logic             last;

  assign in_ready = (state_q == IDLE) && rdy_q;
  assign accept = in_valid && in_ready;
  assign busy = (state_q == ISSUE) || (state_q == WAIT);
  assign last = (k_q == nib_idx_t'(NIBBLES - 1));
  assign cnt_en = (state_q == WAIT);

  cla_lat_counter #(
    .W(CNT_W)
  ) u_lat (
    .clk     (clk),
    .res     (res),
    .load    (load_cnt),
    .load_val(WAIT_INIT),
    .en      (cnt_en),
    .done    (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load_cnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (ADD_LAT == 0) begin
          capture = 1'b1;
          state_d = last ? DONE : ISSUE;
        end else begin
          load_cnt = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_done) begin
          capture = 1'b1;
          state_d = last ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // carry_q doubles as the nibble carry-in: seeded with cin_in at accept.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      state_q <= state_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        carry_q <= cin_in;
        k_q <= '0;
      end
      if (capture) begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (k_q == nib_idx_t'(n)) begin
            sum_q[n*NIBBLE_W+1 +: NIBBLE_W] <= add_z;
          end
        end
        carry_q <= add_cout;
        k_q <= k_q + 1'b1;
      end
    end
  end

  always_comb begin
    add_x = '0;
    add_y = '0;
    add_cin = 1'b0;
    unique case (1'b1)
      busy: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (k_q == nib_idx_t'(n)) begin
            add_x = a_q[n*NIBBLE_W+1 +: NIBBLE_W];
            add_y = b_q[n*NIBBLE_W+1 +: NIBBLE_W];
          end
        end
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign sum = sum_q;
  assign cout_out = carry_q;
  assign ov = (a_q[WIDTH] == b_q[WIDTH]) &&
              (sum_q[WIDTH] != a_q[WIDTH]);

endmodule
